// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_ctrl clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN   = 2;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for clk_div_ctrl: counts 0..div-1, flags terminal count and
// whether the next count value falls in the high phase of clk_out.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic [DIV_W-1:0] div,
    output logic             tc,
    output logic             hi_nxt
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] half;

    always_comb begin
        tc     = (cnt_q == div - DIV_W'(1));
        half   = (div >> 1) + {{(DIV_W-1){1'b0}}, div[0]};
        cnt_d  = adv ? (tc ? '0 : cnt_q + DIV_W'(1)) : cnt_q;
        // A new period always starts high, so the divisor latched at a wrap
        // never disagrees with this flag.
        hi_nxt = (cnt_d < half);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with run/drain FSM and divisor
// change handshake. Define CLK_DIV_ODD_EN to allow odd divisors.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             clk_out,
    output logic             clk_en,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic             adv, tc, hi_nxt;

    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] v);
        logic [DIV_W-1:0] r;
`ifdef CLK_DIV_ODD_EN
        r = v;
`else
        r = {v[DIV_W-1:1], 1'b0};
`endif
        if (r < DIV_W'(DIV_MIN)) r = DIV_W'(DIV_MIN);
        return r;
    endfunction

    assign adv = (state_q != IDLE);

    clk_div_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .adv    (adv),
        .div    (div_q),
        .tc     (tc),
        .hi_nxt (hi_nxt)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ack_d      = 1'b0;

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = tc ? IDLE : DRAIN;
            DRAIN:   if (en) state_d = RUN;
                     else if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE) begin
            if (div_req) begin
                div_d  = norm_div(div_val);
                ack_d  = 1'b1;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = norm_div(pend_val_q);
                ack_d  = 1'b1;
                pend_d = 1'b0;
            end
        end else begin
            // Only a value pending before this boundary may load; a request
            // landing on the boundary waits for the next one.
            if (tc && pend_q) begin
                div_d  = norm_div(pend_val_q);
                ack_d  = 1'b1;
                pend_d = 1'b0;
            end
            if (div_req) begin
                pend_val_d = div_val;
                pend_d     = 1'b1;
            end
        end

        clk_out_d = (state_d != IDLE) && hi_nxt;
        clk_en_d  = (state_d == RUN) && ((state_q == IDLE) || tc);
        busy_d    = (state_d != IDLE) || pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= DIV_W'(DIV_RST);
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            clk_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            clk_out_q <= clk_out_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_val_q <= pend_val_d;
    end

    assign div_ack = ack_q;
    assign clk_out = clk_out_q;
    assign clk_en  = clk_en_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (DIV_W=8, DIV_RST=2).
module tb_clk_div_ctrl;

`ifdef CLK_DIV_ODD_EN
    localparam int D3 = 3;
`else
    localparam int D3 = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       clk_out;
    logic       clk_en;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(.DIV_W(8), .DIV_RST(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Expected vector order: {clk_out, clk_en, div_ack, busy}
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {clk_out, clk_en, div_ack, busy};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed {clk_out,clk_en,div_ack,busy}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

    // Walk counts lo..hi of a running period of divisor d.
    task automatic period(input string tag, input int d, input logic ack0,
                          input int lo, input int hi);
        logic [3:0] exp;
        for (int i = lo; i <= hi; i++) begin
            exp = {(i < (d + 1) / 2), (i == 0), (ack0 && (i == 0)), 1'b1};
            step($sformatf("%s[%0d]", tag, i), exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_init", 4'b0000);
        reset = 1'b0;
        step("idle0", 4'b0000);
        step("idle1", 4'b0000);

        // Default divisor 2 after reset
        en = 1'b1;
        period("d2a", 2, 1'b0, 0, 1);
        period("d2b", 2, 1'b0, 0, 1);

        // Request on the boundary edge waits for the following boundary
        div_req = 1'b1;
        div_val = 8'd4;
        step("bnd_req", 4'b1101);
        div_req = 1'b0;
        step("bnd_wait", 4'b0001);
        period("d4_ack", 4, 1'b1, 0, 3);

        // D=4, request 6 at cnt=1
        period("d4", 4, 1'b0, 0, 1);
        div_req = 1'b1;
        div_val = 8'd6;
        step("d4_c2", 4'b0001);
        div_req = 1'b0;
        step("d4_c3", 4'b0001);
        period("d6_ack", 6, 1'b1, 0, 5);

        // Move to D=8
        period("d6", 6, 1'b0, 0, 0);
        div_req = 1'b1;
        div_val = 8'd8;
        step("d6_c1", 4'b1001);
        div_req = 1'b0;
        period("d6b", 6, 1'b0, 2, 5);
        period("d8_ack", 8, 1'b1, 0, 7);

        // Drop en at cnt=2: period completes, then idle
        period("d8", 8, 1'b0, 0, 2);
        en = 1'b0;
        period("drain", 8, 1'b0, 3, 7);
        step("drain_idle0", 4'b0000);
        step("drain_idle1", 4'b0000);
        step("drain_idle2", 4'b0000);

        // Two requests in one period: only the last one is acknowledged
        en = 1'b1;
        step("d8r_c0", 4'b1101);
        div_req = 1'b1;
        div_val = 8'd5;
        step("d8r_c1", 4'b1001);
        div_val = 8'd10;
        step("d8r_c2", 4'b1001);
        div_req = 1'b0;
        period("d8r", 8, 1'b0, 3, 7);
        period("d10_ack", 10, 1'b1, 0, 9);
        period("d10", 10, 1'b0, 0, 9);
        en = 1'b0;
        step("tc_stop", 4'b0000);

        // Divisor 1 in idle becomes 2, acked next cycle
        div_req = 1'b1;
        div_val = 8'd1;
        step("idle_ack1", 4'b0010);
        div_req = 1'b0;
        step("idle_ack1_off", 4'b0000);
        en = 1'b1;
        period("d1as2a", 2, 1'b0, 0, 1);
        period("d1as2b", 2, 1'b0, 0, 1);
        en = 1'b0;
        step("stop2", 4'b0000);

        // Divisor 3: odd honoured only with CLK_DIV_ODD_EN
        div_req = 1'b1;
        div_val = 8'd3;
        step("idle_ack3", 4'b0010);
        div_req = 1'b0;
        en = 1'b1;
        period("d3a", D3, 1'b0, 0, D3 - 1);
        period("d3b", D3, 1'b0, 0, D3 - 1);

        // Reset mid-period with a change pending
        div_req = 1'b1;
        div_val = 8'd8;
        step("pend_c0", 4'b1101);
        div_req = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_async", 4'b0000);
        @(negedge clk);
        chk("rst_held", 4'b0000);
        en    = 1'b0;
        reset = 1'b0;
        step("post_rst0", 4'b0000);
        step("post_rst1", 4'b0000);
        en = 1'b1;
        period("drst_a", 2, 1'b0, 0, 1);
        period("drst_b", 2, 1'b0, 0, 1);
        step("drst_noack", 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 8, SHALL set the width of the divisor bus and the period counter.
REQ-002 Parameter DIV_RST, default 2, SHALL set the divisor in force after reset.
REQ-003 clk  input  1  SHALL be the single master clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high digital reset.
REQ-005 en  input  1  SHALL run the divider when high and stop it when low.
REQ-006 div_req  input  1  SHALL be a one-cycle request to load div_val as the new divisor.
REQ-007 div_val  input  DIV_W  SHALL be the requested divisor, sampled only when div_req=1.
REQ-008 div_ack  output  1  SHALL pulse for one cycle when the requested divisor takes effect.
REQ-009 clk_out  output  1  SHALL be the registered divided clock.
REQ-010 clk_en  output  1  SHALL pulse for one cycle at the start of each clk_out period.
REQ-011 busy  output  1  SHALL be high when state!=IDLE or when a divisor change is pending.

Function
REQ-012 The effective divisor D SHALL be the loaded value, with values 0 and 1 replaced by 2.
REQ-013 The period counter cnt SHALL run 0..D-1 and wrap to 0; clk_out SHALL be high when cnt<ceil(D/2) and low otherwise.
REQ-014 clk_en SHALL be high exactly in the cycles where cnt==0 in state RUN.
REQ-015 The FSM SHALL have three states: IDLE (cnt=0, clk_out=0), RUN, and DRAIN.
REQ-016 IDLE->RUN SHALL occur on en=1; clk_out=1 and clk_en=1 SHALL appear in the next cycle.
REQ-017 RUN->DRAIN SHALL occur on en=0; DRAIN SHALL complete the current period and enter IDLE at cnt==D-1, so clk_out never produces a runt pulse.
REQ-018 en=1 in DRAIN SHALL return the FSM to RUN without interrupting the period.
REQ-019 div_req SHALL capture div_val into a pending register; in RUN or DRAIN the pending value SHALL load at the cnt==D-1 boundary, with div_ack pulsing in the first cycle of the new period.
REQ-020 In IDLE, a pending value SHALL load in the cycle after div_req, with div_ack pulsing in that cycle.
REQ-021 A div_req arriving while a value is pending SHALL overwrite it; only one div_ack SHALL be issued, for the latest value.
REQ-022 A div_req in the same cycle as the boundary SHALL be applied at the next boundary, not the current one.

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, cnt=0, clk_out=0, clk_en=0, div_ack=0, busy=0, the pending flag cleared, and D=DIV_RST.
REQ-024 Reset asserted in the middle of a period or during a pending change SHALL discard the period and the pending value, with no div_ack.

Configuration
REQ-025 With macro CLK_DIV_ODD_EN defined, any divisor 2..2^DIV_W-1 SHALL be honoured, with high time ceil(D/2) and low time floor(D/2).
REQ-026 Without CLK_DIV_ODD_EN, the divisor LSB SHALL be forced to 0 when loaded, so clk_out duty is always exactly 50%.

Structure
REQ-027 Package clk_div_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN), the DIV_W default and the constant DIV_MIN=2.
REQ-028 Sub-module clk_div_cnt SHALL contain the period counter and provide terminal-count (cnt==D-1) and high-phase flags; all FSM and handshake logic SHALL stay in clk_div_ctrl.

Verification
REQ-029 Reset released, en=1, default D=2 -> clk_out toggles every cycle, clk_en on every second cycle, busy=1.
REQ-030 RUN at D=4, div_req with div_val=6 at cnt=1 -> period completes at 4, div_ack at the next cnt==0, then clk_out high 3 / low 3.
REQ-031 RUN at D=8, en dropped at cnt=2 -> clk_out finishes its 4-high/4-low period, then IDLE with busy=0 and no further clk_en.
REQ-032 Two div_req (5, then 10) within one D=8 period -> single div_ack; new D=10 (or, without CLK_DIV_ODD_EN, the 5 would have become 4 and been overwritten).
REQ-033 div_val=1 in IDLE -> div_ack in the next cycle, D=2; and with CLK_DIV_ODD_EN, D=3 gives high 2 / low 1.
REQ-034 reset pulsed mid-period with a change pending -> all outputs 0 in the same cycle, no div_ack, D=DIV_RST after release.
